// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: key codes, operator and
// state encodings, and the operand magnitude limit derived from digit count.
package calc_pkg;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_EQ  = 4'd12;
   localparam logic [3:0] KEY_CLR = 4'd13;

   localparam int CALC_DIGITS = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   typedef enum logic [2:0] {
      ST_ENTER1      = 3'd0,
      ST_OP_WAIT     = 3'd1,
      ST_ENTER2      = 3'd2,
      ST_CALC        = 3'd3,
      ST_SHOW_RESULT = 3'd4,
      ST_ERROR       = 3'd5
   } state_t;

   // Largest value representable with the given number of decimal digits.
   function automatic int calcMax(input int digits);
      int m;
      m = 1;
      for (int i = 0; i < digits; i++) m = m * 10;
      return m - 1;
   endfunction

   localparam int CALC_MAX = calcMax(CALC_DIGITS);

endpackage

// File: rtl/calc_alu.sv
// Combinational signed add/subtract with a decimal range check: ovf_o flags
// any result whose magnitude exceeds MAX.
module calc_alu #(
   parameter int WIDTH = 16,
   parameter int MAX   = 9999
) (
   input  logic signed [WIDTH-1:0] a_i,
   input  logic signed [WIDTH-1:0] b_i,
   input  logic                    opSub_i,
   output logic signed [WIDTH-1:0] res_o,
   output logic                    ovf_o
);

   localparam logic signed [WIDTH-1:0] MAX_W    = WIDTH'(MAX);
   localparam logic signed [WIDTH-1:0] NEG_MAX_W = -MAX_W;

   always_comb begin
      res_o = opSub_i ? (a_i - b_i) : (a_i + b_i);
      ovf_o = (res_o > MAX_W) || (res_o < NEG_MAX_W);
   end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: accumulates decimal operands from key strobes,
// sequences operand/operator/equals with chaining, result reuse and error.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DIGITS = CALC_DIGITS,
   parameter int WIDTH  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic [WIDTH-1:0] display_value,
   output logic             display_neg,
   output logic             num1_en,
   output logic             num2_en,
   output logic             result_valid,
   output logic             overflow,
   output logic             key_dropped
);

   localparam int MAX   = calcMax(DIGITS);
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);

   // Sums of two in-range operands must never wrap the datapath.
   if ((64'd1 << (WIDTH - 1)) <= 64'(2 * MAX)) begin : g_widthCheck
      $error("calc_sequencer: WIDTH too small for DIGITS");
   end

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] op1_q, op1_d;
   logic signed [WIDTH-1:0] op2_q, op2_d;
   op_t                     op_q, op_d;
   op_t                     pendOp_q, pendOp_d;
   logic                    pendValid_q, pendValid_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    overflow_q, overflow_d;
   logic                    resultValid_q, resultValid_d;
   logic                    keyDropped_q, keyDropped_d;

   logic signed [WIDTH-1:0] aluRes;
   logic                    aluOvf;
   logic                    isDigit, isOp, isEq, isClr;
   op_t                     keyOp;
   logic signed [WIDTH-1:0] digitVal;
   logic signed [WIDTH-1:0] shown;

   function automatic logic signed [WIDTH-1:0] appendDigit(
      input logic signed [WIDTH-1:0] v,
      input logic        [3:0]       d
   );
      return (v <<< 3) + (v <<< 1) + {{(WIDTH-4){1'b0}}, d};
   endfunction

   calc_alu #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
   ) u_alu (
      .a_i     (op1_q),
      .b_i     (op2_q),
      .opSub_i (op_q == OP_SUB),
      .res_o   (aluRes),
      .ovf_o   (aluOvf)
   );

   always_comb begin
      isDigit  = key_valid && (key_code <= 4'd9);
      isOp     = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
      isEq     = key_valid && (key_code == KEY_EQ);
      isClr    = key_valid && (key_code == KEY_CLR);
      keyOp    = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
      digitVal = {{(WIDTH-4){1'b0}}, key_code};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_ENTER1;
         op1_q         <= '0;
         op2_q         <= '0;
         op_q          <= OP_ADD;
         pendOp_q      <= OP_ADD;
         pendValid_q   <= 1'b0;
         cnt_q         <= '0;
         overflow_q    <= 1'b0;
         resultValid_q <= 1'b0;
         keyDropped_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         op1_q         <= op1_d;
         op2_q         <= op2_d;
         op_q          <= op_d;
         pendOp_q      <= pendOp_d;
         pendValid_q   <= pendValid_d;
         cnt_q         <= cnt_d;
         overflow_q    <= overflow_d;
         resultValid_q <= resultValid_d;
         keyDropped_q  <= keyDropped_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op1_d         = op1_q;
      op2_d         = op2_q;
      op_d          = op_q;
      pendOp_d      = pendOp_q;
      pendValid_d   = pendValid_q;
      cnt_d         = cnt_q;
      overflow_d    = overflow_q;
      resultValid_d = 1'b0;
      keyDropped_d  = 1'b0;

      if (isClr && (state_q != ST_CALC)) begin
         state_d     = ST_ENTER1;
         op1_d       = '0;
         op2_d       = '0;
         op_d        = OP_ADD;
         pendOp_d    = OP_ADD;
         pendValid_d = 1'b0;
         cnt_d       = '0;
         overflow_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ENTER1: begin
               if (isDigit && (cnt_q < DIGITS_C)) begin
                  op1_d = appendDigit(op1_q, key_code);
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (isOp) begin
                  op_d    = keyOp;
                  cnt_d   = '0;
                  state_d = ST_OP_WAIT;
               end
            end
            ST_OP_WAIT: begin
               if (isDigit) begin
                  op2_d   = digitVal;
                  cnt_d   = CNT_W'(1);
                  state_d = ST_ENTER2;
               end else if (isOp) begin
                  op_d = keyOp;
               end
            end
            ST_ENTER2: begin
               if (isDigit && (cnt_q < DIGITS_C)) begin
                  op2_d = appendDigit(op2_q, key_code);
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (isEq) begin
                  pendValid_d = 1'b0;
                  state_d     = ST_CALC;
               end else if (isOp) begin
                  pendOp_d    = keyOp;
                  pendValid_d = 1'b1;
                  state_d     = ST_CALC;
               end
            end
            // Any key arriving here is lost; the keypad has no queue.
            ST_CALC: begin
               keyDropped_d = key_valid;
               pendValid_d  = 1'b0;
               if (aluOvf) begin
                  overflow_d = 1'b1;
                  state_d    = ST_ERROR;
               end else if (pendValid_q) begin
                  op1_d   = aluRes;
                  op_d    = pendOp_q;
                  op2_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_OP_WAIT;
               end else begin
                  op1_d         = aluRes;
                  resultValid_d = 1'b1;
                  state_d       = ST_SHOW_RESULT;
               end
            end
            ST_SHOW_RESULT: begin
               if (isDigit) begin
                  op1_d   = digitVal;
                  cnt_d   = CNT_W'(1);
                  state_d = ST_ENTER1;
               end else if (isOp) begin
                  op_d    = keyOp;
                  cnt_d   = '0;
                  state_d = ST_OP_WAIT;
               end else if (isEq) begin
                  pendValid_d = 1'b0;
                  state_d     = ST_CALC;
               end
            end
            ST_ERROR: begin
               overflow_d = 1'b1;
            end
            default: begin
               state_d = ST_ENTER1;
            end
         endcase
      end
   end

   always_comb begin
      case (state_q)
         ST_ENTER2: shown = op2_q;
         ST_ERROR:  shown = '0;
         ST_CALC:   shown = op1_q;
         default:   shown = op1_q;
      endcase
      display_neg   = shown[WIDTH-1];
      display_value = display_neg ? -shown : shown;
      num1_en       = (state_q == ST_ENTER1) || (state_q == ST_SHOW_RESULT);
      num2_en       = (state_q == ST_OP_WAIT) || (state_q == ST_ENTER2);
      result_valid  = resultValid_q;
      overflow      = overflow_q;
      key_dropped   = keyDropped_q;
   end

endmodule
